// File: rtl/deserializator.sv
// Serial-to-parallel receiver: collects MSB-first frames of 1..DATA_W bits and
// emits each left-aligned word with its bit count; frames shorter than MIN_LEN are flagged.
module deserializator #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  sh, sh_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]  data_n;
  logic [MOD_W-1:0]   mod_n;
  logic               val_n, err_n;

  logic [DATA_W-1:0]  base;
  logic [DATA_W-1:0]  sh_cap;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      sh               <= '0;
      cnt              <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      frame_err_o      <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      state            <= state_n;
      sh               <= sh_n;
      cnt              <= cnt_n;
      deser_data_o     <= data_n;
      deser_data_mod_o <= mod_n;
      deser_data_val_o <= val_n;
      frame_err_o      <= err_n;
      busy_o           <= (cnt_n != '0);
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    data_n  = deser_data_o;
    mod_n   = deser_data_mod_o;
    val_n   = 1'b0;
    err_n   = 1'b0;

    // The first bit of a frame starts from a cleared register so short frames
    // come out with zeroed LSBs.
    base    = (state == IDLE) ? '0 : sh;
    sh_cap  = base | (DATA_W'(ser_data_i) << (CNT_W'(DATA_W - 1) - cnt));
    cnt_inc = cnt + CNT_W'(1);

    if (ser_data_val_i) begin
      if (cnt_inc == CNT_W'(DATA_W)) begin
        val_n   = 1'b1;
        data_n  = sh_cap;
        mod_n   = '0;
        sh_n    = sh_cap;
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        sh_n    = sh_cap;
        cnt_n   = cnt_inc;
        state_n = COLLECT;
      end
    end else if (state == COLLECT) begin
      if (cnt >= CNT_W'(MIN_LEN)) begin
        val_n  = 1'b1;
        data_n = sh;
        mod_n  = cnt[MOD_W-1:0];
      end else begin
        err_n  = 1'b1;
      end
      cnt_n   = '0;
      state_n = IDLE;
    end
  end

endmodule

// File: doc/deserializator.md
Name: deserializator

Overview:
- Receive-side counterpart of the team's serializer.
- Accepts an MSB-first serial bit stream qualified by a valid strobe and reassembles frames of 1..DATA_W bits into parallel words.
- Outputs each word with its bit count, encoded in the same `data_mod` format the serializer accepts.
- Sits at the far end of the serial link and feeds parallel consumers; frames too short to be legal are flagged as errors.

Parameters:
- DATA_W, 16: maximum frame length in bits; parallel word width.
- MOD_W, $clog2(DATA_W): width of the bit-count output (4 for 16).
- MIN_LEN, 3: shortest legal frame. Shorter frames are dropped and flagged.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- ser_data_i  input  1  serial data bit.
- ser_data_val_i  input  1  ser_data_i valid this cycle; a low cycle after ≥1 valid bit ends the frame.
- deser_data_o  output  DATA_W  assembled word, left-aligned: first received bit at [DATA_W-1], unused LSBs 0.
- deser_data_mod_o  output  MOD_W  number of valid bits; DATA_W encoded as 0.
- deser_data_val_o  output  1  one-cycle pulse; deser_data_o and deser_data_mod_o are valid.
- frame_err_o  output  1  one-cycle pulse; a frame shorter than MIN_LEN was discarded.
- busy_o  output  1  high while a frame is being collected (bit count > 0).

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - All outputs 0.
  - Shift register and bit counter 0.
  - State IDLE.
  - Reset mid-frame discards the partial frame with no output pulse.
- Internal state:
  - Shift register sh[DATA_W-1:0].
  - Counter cnt, width $clog2(DATA_W+1), range 0..DATA_W.
- States:
  - IDLE (cnt==0).
  - COLLECT (0<cnt<DATA_W).
  - Reaching DATA_W bits returns to IDLE in the same edge.
- Bit capture:
  - On an edge with ser_data_val_i=1, the bit is written at position DATA_W-1-cnt and cnt increments. Equivalently, bits are placed left-aligned, MSB first.
  - Any bit captured when entering COLLECT from IDLE clears the remainder of sh.
- Full-frame completion:
  - On the edge capturing bit number DATA_W: deser_data_val_o=1 next cycle, deser_data_o = the full word, deser_data_mod_o=0, cnt←0.
  - If ser_data_val_i stays high on the next edge, that bit starts a new frame (cnt=1) with no idle gap required.
  - Back-to-back full frames therefore produce a val pulse every DATA_W cycles.
- Gap completion:
  - Applies on an edge with ser_data_val_i=0 and cnt>0.
  - If cnt≥MIN_LEN: deser_data_val_o=1, deser_data_o=sh (LSBs below the frame zero), deser_data_mod_o=cnt[MOD_W-1:0].
  - If cnt<MIN_LEN: frame_err_o=1, deser_data_val_o=0, deser_data_o unchanged.
  - In both cases cnt←0.
- Latency: exactly one clock from the terminating edge to the output pulse.
- Output holding: deser_data_o and deser_data_mod_o hold their last emitted value until the next emission. The val and err pulses last one cycle.
- busy_o = (cnt != 0), registered. It is low in the cycle the val/err pulse is high unless a new frame began on that edge.
- ser_data_val_i=0 with cnt==0: no action; no err pulse for idle cycles.
- ser_data_i is ignored whenever ser_data_val_i=0.
- deser_data_val_o and frame_err_o are never high together.

Test Plan:
- Reset mid-frame: 5 valid bits, assert rst_i asynchronously between edges, then feed a 3-bit frame 101 → outputs 0 immediately on reset assertion, no pulse for the partial frame; then val pulse with data 0xA000, mod 3.
- Full frame: 16 consecutive valid bits of 0xBEEF MSB first → one cycle after the 16th bit, val=1, data=0xBEEF, mod=0; busy_o high during bits 2..16.
- Variable length: 5 bits 11010 then val low → val pulse one cycle after the low edge, data=0xD000, mod=5.
- Back-to-back: 0x1234 then 0xFFFF streamed with no gap (32 valid cycles) → two val pulses 16 cycles apart, data 0x1234 then 0xFFFF, both mod 0.
- Short frames: 1 bit then gap; 2 bits then gap → two frame_err_o pulses, no val, deser_data_o keeps its previous value; then 3-bit frame 111 → data 0xE000, mod 3.
- Loopback with the serializer: random data_i and data_mod_i in {0,3..15} → each received word equals data_i[15:16-n] left-aligned (n = mod, 0→16), and the mod matches.
